regfile_scb: RTL and testbench

REGFILE_SCB -- requirements
Module: regfile_scb

---
 rtl/regfile_scb_if.sv | 37 +++
 rtl/regfile_scb.sv | 124 ++++++++++++
 tb/tb_regfile_scb.sv | 343 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_scb_if.sv
// Bus bundle for regfile_scb: read ports, writeback ports, issue ports and flush.
// The master modport drives the requests; the slave modport is the register file.
interface regfile_scb_if #(
    parameter int DATA_W = 64,
    parameter int NREG   = 32,
    parameter int NRD    = 4,
    parameter int NWR    = 2,
    parameter int NISS   = 2,
    parameter int TAG_W  = 6
);
    localparam int ADDR_W = (NREG > 1) ? $clog2(NREG) : 1;

    logic [NRD*ADDR_W-1:0]  i_raddr;
    logic [NRD*DATA_W-1:0]  o_rdata;
    logic [NRD-1:0]         o_rbusy;
    logic [NRD*TAG_W-1:0]   o_rtag;
    logic [NWR-1:0]         i_we;
    logic [NWR*ADDR_W-1:0]  i_waddr;
    logic [NWR*DATA_W-1:0]  i_wdata;
    logic [NWR*TAG_W-1:0]   i_wtag;
    logic [NISS-1:0]        i_iss_vld;
    logic [NISS*ADDR_W-1:0] i_iss_addr;
    logic [NISS*TAG_W-1:0]  i_iss_tag;
    logic                   i_flush;

    modport master (
        output i_raddr, i_we, i_waddr, i_wdata, i_wtag,
               i_iss_vld, i_iss_addr, i_iss_tag, i_flush,
        input  o_rdata, o_rbusy, o_rtag
    );

    modport slave (
        input  i_raddr, i_we, i_waddr, i_wdata, i_wtag,
               i_iss_vld, i_iss_addr, i_iss_tag, i_flush,
        output o_rdata, o_rbusy, o_rtag
    );
endinterface

// File: rtl/regfile_scb.sv
// Multi-ported architectural register file with a per-register scoreboard
// (busy bit + producer tag). Reads are combinational with write-to-read
// bypass; register 0 and out-of-range addresses are hardwired to zero/idle.
module regfile_scb #(
    parameter int DATA_W = 64,
    parameter int NREG   = 32,
    parameter int NRD    = 4,
    parameter int NWR    = 2,
    parameter int NISS   = 2,
    parameter int TAG_W  = 6
) (
    input logic          clk,
    input logic          rst_n,
    regfile_scb_if.slave bus
);
    localparam int ADDR_W = (NREG > 1) ? $clog2(NREG) : 1;

    // Architectural state
    logic [DATA_W-1:0] mem_r  [NREG];
    logic              busy_r [NREG];
    logic [TAG_W-1:0]  tag_r  [NREG];

    // Next-state values
    logic [DATA_W-1:0] mem_nxt_s  [NREG];
    logic              busy_nxt_s [NREG];
    logic [TAG_W-1:0]  tag_nxt_s  [NREG];

    // Combinational read results
    logic [NRD*DATA_W-1:0] rdata_s;
    logic [NRD-1:0]        rbusy_s;
    logic [NRD*TAG_W-1:0]  rtag_s;

    // A real register: nonzero and inside the implemented range.
    function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
        return (a != {ADDR_W{1'b0}}) && (int'(a) < NREG);
    endfunction

    // Read ports: stored state, overridden by same-cycle writebacks (highest port last, so it wins).
    always_comb begin
        logic [ADDR_W-1:0] ra_s;
        logic [ADDR_W-1:0] wa_s;
        logic              hit_s;
        rdata_s = {(NRD*DATA_W){1'b0}};
        rbusy_s = {NRD{1'b0}};
        rtag_s  = {(NRD*TAG_W){1'b0}};
        ra_s    = {ADDR_W{1'b0}};
        wa_s    = {ADDR_W{1'b0}};
        hit_s   = 1'b0;
        for (int k = 0; k < NRD; k++) begin
            ra_s = bus.i_raddr[k*ADDR_W +: ADDR_W];
            if (rst_n && addr_ok(ra_s)) begin
                rdata_s[k*DATA_W +: DATA_W] = mem_r[ra_s];
                rbusy_s[k]                  = busy_r[ra_s];
                rtag_s[k*TAG_W +: TAG_W]    = tag_r[ra_s];
                for (int j = 0; j < NWR; j++) begin
                    wa_s  = bus.i_waddr[j*ADDR_W +: ADDR_W];
                    hit_s = bus.i_we[j] && (wa_s == ra_s);
                    rdata_s[k*DATA_W +: DATA_W] = hit_s ? bus.i_wdata[j*DATA_W +: DATA_W]
                                                        : rdata_s[k*DATA_W +: DATA_W];
                    // A matching writeback retires the producer this very cycle.
                    rbusy_s[k] = (hit_s && busy_r[ra_s] &&
                                  (bus.i_wtag[j*TAG_W +: TAG_W] == tag_r[ra_s]))
                                 ? 1'b0 : rbusy_s[k];
                end
            end else begin
                rdata_s[k*DATA_W +: DATA_W] = {DATA_W{1'b0}};
                rbusy_s[k]                  = 1'b0;
                rtag_s[k*TAG_W +: TAG_W]    = {TAG_W{1'b0}};
            end
        end
    end

    assign bus.o_rdata = rdata_s;
    assign bus.o_rbusy = rbusy_s;
    assign bus.o_rtag  = rtag_s;

    // Next state: writes, then tag-matched busy clears, then issues (issue beats writeback), then flush.
    always_comb begin
        logic hit_s;
        hit_s = 1'b0;
        for (int r = 0; r < NREG; r++) begin
            mem_nxt_s[r]  = mem_r[r];
            busy_nxt_s[r] = busy_r[r];
            tag_nxt_s[r]  = tag_r[r];
            if (r != 0) begin
                for (int j = 0; j < NWR; j++) begin
                    hit_s = bus.i_we[j] && (bus.i_waddr[j*ADDR_W +: ADDR_W] == ADDR_W'(r));
                    mem_nxt_s[r]  = hit_s ? bus.i_wdata[j*DATA_W +: DATA_W] : mem_nxt_s[r];
                    busy_nxt_s[r] = (hit_s && busy_r[r] &&
                                     (bus.i_wtag[j*TAG_W +: TAG_W] == tag_r[r]))
                                    ? 1'b0 : busy_nxt_s[r];
                end
                for (int i = 0; i < NISS; i++) begin
                    hit_s = bus.i_iss_vld[i] &&
                            (bus.i_iss_addr[i*ADDR_W +: ADDR_W] == ADDR_W'(r));
                    busy_nxt_s[r] = hit_s ? 1'b1 : busy_nxt_s[r];
                    tag_nxt_s[r]  = hit_s ? bus.i_iss_tag[i*TAG_W +: TAG_W] : tag_nxt_s[r];
                end
                busy_nxt_s[r] = bus.i_flush ? 1'b0 : busy_nxt_s[r];
            end else begin
                mem_nxt_s[r]  = {DATA_W{1'b0}};
                busy_nxt_s[r] = 1'b0;
                tag_nxt_s[r]  = {TAG_W{1'b0}};
            end
        end
    end

    // State registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < NREG; r++) begin
                mem_r[r]  <= {DATA_W{1'b0}};
                busy_r[r] <= 1'b0;
                tag_r[r]  <= {TAG_W{1'b0}};
            end
        end else begin
            for (int r = 0; r < NREG; r++) begin
                mem_r[r]  <= mem_nxt_s[r];
                busy_r[r] <= busy_nxt_s[r];
                tag_r[r]  <= tag_nxt_s[r];
            end
        end
    end
endmodule

// File: tb/tb_regfile_scb.sv
// Directed self-checking bench for regfile_scb (default parameters).
module tb_regfile_scb;
    localparam int DW = 64;
    localparam int AW = 5;
    localparam int TW = 6;
    localparam int NRD = 4;

    logic clk;
    logic rst_n;
    int   errors;
    int   checks;

    regfile_scb_if bus ();

    regfile_scb dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Free-running clock, period 10.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [DW-1:0] rd(input int k);
        return bus.o_rdata[k*DW +: DW];
    endfunction

    function automatic logic [TW-1:0] rt(input int k);
        return bus.o_rtag[k*TW +: TW];
    endfunction

    task automatic clear_inputs();
        bus.i_raddr    = '0;
        bus.i_we       = '0;
        bus.i_waddr    = '0;
        bus.i_wdata    = '0;
        bus.i_wtag     = '0;
        bus.i_iss_vld  = '0;
        bus.i_iss_addr = '0;
        bus.i_iss_tag  = '0;
        bus.i_flush    = 1'b0;
    endtask

    task automatic set_raddr(input int k, input logic [AW-1:0] a);
        bus.i_raddr[k*AW +: AW] = a;
    endtask

    task automatic drive_wr(input int j, input logic [AW-1:0] a,
                            input logic [DW-1:0] d, input logic [TW-1:0] t);
        bus.i_we[j]             = 1'b1;
        bus.i_waddr[j*AW +: AW] = a;
        bus.i_wdata[j*DW +: DW] = d;
        bus.i_wtag[j*TW +: TW]  = t;
    endtask

    task automatic drive_iss(input int i, input logic [AW-1:0] a, input logic [TW-1:0] t);
        bus.i_iss_vld[i]           = 1'b1;
        bus.i_iss_addr[i*AW +: AW] = a;
        bus.i_iss_tag[i*TW +: TW]  = t;
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        clear_inputs();
        for (int k = 0; k < NRD; k++) set_raddr(k, 5'd5);
        drive_wr(0, 5'd5, 64'hABCD, 6'd0);
        #3;
        checks++;
        if (rd(0) !== 64'h0) begin
            errors++;
            $display("FAIL reset_hold_bypass: got %h expected %h", rd(0), 64'h0);
        end
        clear_inputs();
        for (int k = 0; k < NRD; k++) set_raddr(k, 5'd5);
        tick();
        tick();
        rst_n = 1'b1;
        #1;
        for (int k = 0; k < NRD; k++) begin
            checks++;
            if (rd(k) !== 64'h0) begin
                errors++;
                $display("FAIL reset_rdata port %0d: got %h expected %h", k, rd(k), 64'h0);
            end
            checks++;
            if (bus.o_rbusy[k] !== 1'b0) begin
                errors++;
                $display("FAIL reset_rbusy port %0d: got %b expected 0", k, bus.o_rbusy[k]);
            end
        end
    endtask

    task automatic test_bypass();
        tick();
        clear_inputs();
        drive_wr(0, 5'd3, 64'hDEAD, 6'd0);
        set_raddr(0, 5'd3);
        set_raddr(2, 5'd3);
        #1;
        checks++;
        if (rd(0) !== 64'hDEAD) begin
            errors++;
            $display("FAIL bypass_r3: got %h expected %h", rd(0), 64'hDEAD);
        end
        checks++;
        if (rd(2) !== 64'hDEAD) begin
            errors++;
            $display("FAIL bypass_r3_port2: got %h expected %h", rd(2), 64'hDEAD);
        end
        tick();
        clear_inputs();
        set_raddr(1, 5'd3);
        #1;
        checks++;
        if (rd(1) !== 64'hDEAD) begin
            errors++;
            $display("FAIL storage_r3: got %h expected %h", rd(1), 64'hDEAD);
        end
    endtask

    task automatic test_multi_write();
        tick();
        clear_inputs();
        drive_wr(0, 5'd7, 64'h11, 6'd0);
        drive_wr(1, 5'd7, 64'h22, 6'd0);
        set_raddr(1, 5'd7);
        #1;
        checks++;
        if (rd(1) !== 64'h22) begin
            errors++;
            $display("FAIL multi_bypass_r7: got %h expected %h", rd(1), 64'h22);
        end
        tick();
        clear_inputs();
        set_raddr(3, 5'd7);
        #1;
        checks++;
        if (rd(3) !== 64'h22) begin
            errors++;
            $display("FAIL multi_storage_r7: got %h expected %h", rd(3), 64'h22);
        end
        drive_wr(0, 5'd0, 64'hFF, 6'd0);
        drive_iss(0, 5'd0, 6'd1);
        set_raddr(0, 5'd0);
        #1;
        checks++;
        if (rd(0) !== 64'h0) begin
            errors++;
            $display("FAIL r0_bypass: got %h expected %h", rd(0), 64'h0);
        end
        tick();
        clear_inputs();
        set_raddr(0, 5'd0);
        #1;
        checks++;
        if (rd(0) !== 64'h0 || bus.o_rbusy[0] !== 1'b0) begin
            errors++;
            $display("FAIL r0_storage: got %h busy %b expected 0 busy 0", rd(0), bus.o_rbusy[0]);
        end
    endtask

    task automatic test_scoreboard();
        tick();
        clear_inputs();
        drive_iss(0, 5'd4, 6'd5);
        set_raddr(0, 5'd4);
        #1;
        checks++;
        if (bus.o_rbusy[0] !== 1'b0) begin
            errors++;
            $display("FAIL issue_same_cycle_busy: got %b expected 0", bus.o_rbusy[0]);
        end
        tick();
        clear_inputs();
        set_raddr(0, 5'd4);
        #1;
        checks++;
        if (bus.o_rbusy[0] !== 1'b1 || rt(0) !== 6'd5) begin
            errors++;
            $display("FAIL issue_r4: got busy %b tag %0d expected busy 1 tag 5", bus.o_rbusy[0], rt(0));
        end
        drive_wr(0, 5'd4, 64'hAA, 6'd3);
        #1;
        checks++;
        if (bus.o_rbusy[0] !== 1'b1 || rd(0) !== 64'hAA) begin
            errors++;
            $display("FAIL wb_mismatch_comb: got busy %b data %h expected busy 1 data aa", bus.o_rbusy[0], rd(0));
        end
        tick();
        clear_inputs();
        set_raddr(0, 5'd4);
        #1;
        checks++;
        if (bus.o_rbusy[0] !== 1'b1 || rt(0) !== 6'd5 || rd(0) !== 64'hAA) begin
            errors++;
            $display("FAIL wb_mismatch_reg: got busy %b tag %0d data %h expected 1 5 aa", bus.o_rbusy[0], rt(0), rd(0));
        end
        drive_wr(1, 5'd4, 64'hBB, 6'd5);
        #1;
        checks++;
        if (bus.o_rbusy[0] !== 1'b0 || rd(0) !== 64'hBB) begin
            errors++;
            $display("FAIL wb_match_comb: got busy %b data %h expected busy 0 data bb", bus.o_rbusy[0], rd(0));
        end
        tick();
        clear_inputs();
        set_raddr(0, 5'd4);
        #1;
        checks++;
        if (bus.o_rbusy[0] !== 1'b0 || rd(0) !== 64'hBB) begin
            errors++;
            $display("FAIL wb_match_reg: got busy %b data %h expected busy 0 data bb", bus.o_rbusy[0], rd(0));
        end
        drive_iss(0, 5'd11, 6'd1);
        drive_iss(1, 5'd11, 6'd3);
        tick();
        clear_inputs();
        set_raddr(2, 5'd11);
        #1;
        checks++;
        if (bus.o_rbusy[2] !== 1'b1 || rt(2) !== 6'd3) begin
            errors++;
            $display("FAIL issue_conflict_r11: got busy %b tag %0d expected busy 1 tag 3", bus.o_rbusy[2], rt(2));
        end
    endtask

    task automatic test_issue_wb_flush();
        tick();
        clear_inputs();
        drive_iss(0, 5'd9, 6'd7);
        tick();
        clear_inputs();
        drive_iss(1, 5'd9, 6'd2);
        drive_wr(0, 5'd9, 64'h99, 6'd7);
        set_raddr(1, 5'd9);
        #1;
        checks++;
        if (bus.o_rbusy[1] !== 1'b0) begin
            errors++;
            $display("FAIL iss_wb_comb_busy: got %b expected 0", bus.o_rbusy[1]);
        end
        tick();
        clear_inputs();
        set_raddr(1, 5'd9);
        #1;
        checks++;
        if (bus.o_rbusy[1] !== 1'b1 || rt(1) !== 6'd2 || rd(1) !== 64'h99) begin
            errors++;
            $display("FAIL iss_beats_wb: got busy %b tag %0d data %h expected 1 2 99", bus.o_rbusy[1], rt(1), rd(1));
        end
        bus.i_flush = 1'b1;
        drive_iss(0, 5'd9, 6'd4);
        drive_wr(0, 5'd10, 64'h55, 6'd0);
        tick();
        clear_inputs();
        set_raddr(1, 5'd9);
        set_raddr(2, 5'd10);
        set_raddr(3, 5'd11);
        #1;
        checks++;
        if (bus.o_rbusy[1] !== 1'b0) begin
            errors++;
            $display("FAIL flush_r9_busy: got %b expected 0", bus.o_rbusy[1]);
        end
        checks++;
        if (bus.o_rbusy[3] !== 1'b0) begin
            errors++;
            $display("FAIL flush_r11_busy: got %b expected 0", bus.o_rbusy[3]);
        end
        checks++;
        if (rd(2) !== 64'h55) begin
            errors++;
            $display("FAIL flush_write_r10: got %h expected %h", rd(2), 64'h55);
        end
    endtask

    task automatic test_async_reset();
        tick();
        clear_inputs();
        drive_wr(0, 5'd20, 64'h1234, 6'd0);
        drive_iss(0, 5'd21, 6'd9);
        tick();
        clear_inputs();
        set_raddr(0, 5'd20);
        set_raddr(1, 5'd21);
        #1;
        checks++;
        if (rd(0) !== 64'h1234 || bus.o_rbusy[1] !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset_state: got data %h busy %b expected 1234 1", rd(0), bus.o_rbusy[1]);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (rd(0) !== 64'h0 || bus.o_rbusy[1] !== 1'b0 || rt(1) !== 6'd0) begin
            errors++;
            $display("FAIL async_reset: got data %h busy %b tag %0d expected 0 0 0", rd(0), bus.o_rbusy[1], rt(1));
        end
        tick();
        rst_n = 1'b1;
        #1;
        checks++;
        if (rd(0) !== 64'h0 || bus.o_rbusy[1] !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_state: got data %h busy %b expected 0 0", rd(0), bus.o_rbusy[1]);
        end
        drive_wr(1, 5'd20, 64'h42, 6'd0);
        tick();
        clear_inputs();
        set_raddr(0, 5'd20);
        #1;
        checks++;
        if (rd(0) !== 64'h42) begin
            errors++;
            $display("FAIL first_write_after_reset: got %h expected %h", rd(0), 64'h42);
        end
    endtask

    // Test sequence.
    initial begin
        errors = 0;
        checks = 0;
        rst_n  = 1'b0;
        clear_inputs();
        test_reset();
        test_bypass();
        test_multi_write();
        test_scoreboard();
        test_issue_wb_flush();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
